// File: rtl/multiplica_if.sv
// Operand/result bundle shared by the sequencer and the multiplier.
// The sequencer side (master) drives the start request and operands;
// the multiplier side (slave) returns the product, done flag and state code.
interface multiplica_if #(
    parameter int McLen = 8,
    parameter int MpLen = 8
);
    logic                     go;
    logic [McLen-1:0]         mcInput;
    logic [MpLen-1:0]         mpInput;
    logic [McLen+MpLen-1:0]   product;
    logic                     done;
    logic [2:0]               EstPresente;

    modport master (
        output go,
        output mcInput,
        output mpInput,
        input  product,
        input  done,
        input  EstPresente
    );

    modport slave (
        input  go,
        input  mcInput,
        input  mpInput,
        output product,
        output done,
        output EstPresente
    );
endinterface

// File: rtl/multiplica.sv
// Sequential signed shift-and-add multiplier.
// Operands are converted to magnitudes, multiplied one multiplier bit per
// falling clock edge, and the sign is restored at the end. The product
// register is {highQ, lowQ}: lowQ starts out holding the multiplier and is
// shifted out as the product bits shift in from the top.
module multiplica #(
    parameter int McLen = 8,
    parameter int MpLen = 8
) (
    input  logic          reloj,
    input  logic          reset,
    multiplica_if.slave   bus
);

    localparam int CntW = $clog2(MpLen + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ABS   = 3'd2,
        MUL   = 3'd3,
        SIGN  = 3'd4
    } state_t;

    state_t                 stateQ, stateD;
    logic [McLen-1:0]       mcQ, mcD;
    logic [McLen-1:0]       highQ, highD;
    logic [MpLen-1:0]       lowQ, lowD;
    logic                   carryQ, carryD;
    logic [CntW-1:0]        cntQ, cntD;
    logic                   negMcQ, negMcD;
    logic                   negMpQ, negMpD;
    logic                   doneQ, doneD;

    logic [McLen:0]           sumW;
    logic [McLen:0]           preW;
    logic [McLen+MpLen-1:0]   negProdW;

    // One multiply step: optionally add the multiplicand into the high half
    // (with a carry bit), ready to be shifted right by one.
    assign sumW     = {1'b0, highQ} + {1'b0, mcQ};
    assign preW     = lowQ[0] ? sumW : {carryQ, highQ};
    assign negProdW = -{highQ, lowQ};

    assign bus.product     = {highQ, lowQ};
    assign bus.done        = doneQ;
    assign bus.EstPresente = stateQ;

    // Controller state register; reset aborts any operation in flight.
    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            stateQ <= IDLE;
        end else begin
            stateQ <= stateD;
        end
    end

    // Datapath registers; reset clears the result and raises done at once.
    always_ff @(negedge reloj or negedge reset) begin
        if (!reset) begin
            mcQ    <= '0;
            highQ  <= '0;
            lowQ   <= '0;
            carryQ <= 1'b0;
            cntQ   <= '0;
            negMcQ <= 1'b0;
            negMpQ <= 1'b0;
            doneQ  <= 1'b1;
        end else begin
            mcQ    <= mcD;
            highQ  <= highD;
            lowQ   <= lowD;
            carryQ <= carryD;
            cntQ   <= cntD;
            negMcQ <= negMcD;
            negMpQ <= negMpD;
            doneQ  <= doneD;
        end
    end

    // Next-state and datapath update for each controller state.
    always_comb begin
        stateD = stateQ;
        mcD    = mcQ;
        highD  = highQ;
        lowD   = lowQ;
        carryD = carryQ;
        cntD   = cntQ;
        negMcD = negMcQ;
        negMpD = negMpQ;
        doneD  = doneQ;

        case (stateQ)
            IDLE: begin
                doneD = 1'b1;
                if (bus.go) begin
                    mcD    = bus.mcInput;
                    lowD   = bus.mpInput;
                    highD  = '0;
                    carryD = 1'b0;
                    doneD  = 1'b0;
                    stateD = CHECK;
                end
            end

            CHECK: begin
                if (mcQ == '0 || lowQ == '0) begin
                    highD  = '0;
                    lowD   = '0;
                    carryD = 1'b0;
                    doneD  = 1'b1;
                    stateD = IDLE;
                end else begin
                    negMcD = mcQ[McLen-1];
                    negMpD = lowQ[MpLen-1];
                    stateD = ABS;
                end
            end

            ABS: begin
                // The most negative value negates to its own bit pattern,
                // which read as unsigned is exactly the right magnitude.
                if (negMcQ) begin
                    mcD = -mcQ;
                end
                if (negMpQ) begin
                    lowD = -lowQ;
                end
                cntD   = '0;
                stateD = MUL;
            end

            MUL: begin
                carryD = 1'b0;
                highD  = preW[McLen:1];
                lowD   = {preW[0], lowQ[MpLen-1:1]};
                cntD   = cntQ + CntW'(1);
                if (cntQ == CntW'(MpLen - 1)) begin
                    stateD = SIGN;
                end
            end

            SIGN: begin
                if (negMcQ ^ negMpQ) begin
                    {highD, lowD} = negProdW;
                end
                doneD  = 1'b1;
                stateD = IDLE;
            end

            default: begin
                doneD  = 1'b1;
                stateD = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multiplica.sv
// Scoreboard bench for the signed sequential multiplier.
// Stimulus pushes the hand-computed product and expected latency; a
// separate monitor pops and compares whenever done rises.
module tb_multiplica;

    logic reloj;
    logic reset;

    multiplica_if #(.McLen(8), .MpLen(8)) bus ();

    multiplica #(.McLen(8), .MpLen(8)) dut (
        .reloj (reloj),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] prod;
        int          lat;
        string       name;
    } exp_t;

    exp_t sbQueue[$];
    int   testsRun    = 0;
    int   testsFailed = 0;

    // Free-running clock; the DUT acts on falling edges, the bench on rising.
    initial begin
        reloj = 1'b0;
        forever #5 reloj = ~reloj;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic pushExpected(input logic [15:0] prod, input int lat, input string name);
        exp_t e;
        e.prod = prod;
        e.lat  = lat;
        e.name = name;
        sbQueue.push_back(e);
    endtask

    // Raise go with operands at a rising edge; capture happens on the next falling edge.
    task automatic startOp(input logic [7:0] mc, input logic [7:0] mp,
                           input logic [15:0] prod, input int lat, input string name);
        @(posedge reloj);
        bus.go      = 1'b1;
        bus.mcInput = mc;
        bus.mpInput = mp;
        pushExpected(prod, lat, name);
    endtask

    task automatic waitDone(input string name);
        int n;
        n = 0;
        while (!bus.done && n < 30) begin
            @(posedge reloj);
            n++;
        end
        if (!bus.done) begin
            checkOutput({name, "_timeout"}, 0, 1);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] mc, input logic [7:0] mp,
                                 input logic [15:0] prod, input int lat, input string name);
        startOp(mc, mp, prod, lat, name);
        @(posedge reloj);
        bus.go = 1'b0;
        waitDone(name);
    endtask

    // Monitor: time each busy period and compare the result when done rises.
    initial begin
        int   cycle;
        int   startCyc;
        logic prevDone;
        exp_t e;
        cycle    = 0;
        startCyc = 0;
        prevDone = 1'b1;
        forever begin
            @(posedge reloj);
            cycle++;
            if (prevDone && !bus.done) begin
                startCyc = cycle;
            end
            if (!prevDone && bus.done) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput({e.name, "_product"}, int'(bus.product), int'(e.prod));
                    if (e.lat >= 0) begin
                        checkOutput({e.name, "_latency"}, cycle - startCyc, e.lat);
                    end
                end
            end
            prevDone = bus.done;
        end
    end

    // Directed stimulus sequence.
    initial begin
        int expSeq[12];
        expSeq = '{1, 2, 3, 3, 3, 3, 3, 3, 3, 3, 4, 0};

        bus.go      = 1'b0;
        bus.mcInput = '0;
        bus.mpInput = '0;
        reset       = 1'b1;
        #1 reset    = 1'b0;
        #2;
        checkOutput("reset_done",    int'(bus.done), 1);
        checkOutput("reset_product", int'(bus.product), 0);
        checkOutput("reset_state",   int'(bus.EstPresente), 0);
        @(posedge reloj);
        @(posedge reloj);
        reset = 1'b1;

        // 7 x -3 with a cycle-by-cycle state trace.
        startOp(8'd7, 8'hFD, 16'hFFEB, 11, "mul_7_m3");
        for (int i = 0; i < 12; i++) begin
            @(posedge reloj);
            if (i == 0) begin
                bus.go = 1'b0;
            end
            checkOutput($sformatf("state_seq_%0d", i), int'(bus.EstPresente), expSeq[i]);
        end

        applyStimulus(8'h80, 8'h80, 16'h4000, 11, "mul_m128_m128");
        applyStimulus(8'd127, 8'd127, 16'h3F01, 11, "mul_127_127");
        applyStimulus(8'h80, 8'd127, 16'hC080, 11, "mul_m128_127");
        applyStimulus(8'd0, 8'hFB, 16'h0000, 1, "zero_0_m5");
        applyStimulus(8'd9, 8'd0, 16'h0000, 1, "zero_9_0");

        // A go pulse during MUL with new operands must be ignored.
        startOp(8'd3, 8'd4, 16'h000C, 11, "ignore_go");
        @(posedge reloj);
        bus.go = 1'b0;
        repeat (3) @(posedge reloj);
        checkOutput("ignore_go_in_mul", int'(bus.EstPresente), 3);
        bus.go      = 1'b1;
        bus.mcInput = 8'd100;
        bus.mpInput = 8'd100;
        @(posedge reloj);
        bus.go = 1'b0;
        waitDone("ignore_go");

        // Asynchronous reset in the middle of MUL, between clock edges.
        startOp(8'd50, 8'd3, 16'h0000, -1, "abort");
        @(posedge reloj);
        bus.go = 1'b0;
        repeat (4) @(posedge reloj);
        #3 reset = 1'b0;
        #1;
        checkOutput("abort_done",    int'(bus.done), 1);
        checkOutput("abort_product", int'(bus.product), 0);
        checkOutput("abort_state",   int'(bus.EstPresente), 0);
        repeat (2) @(posedge reloj);
        reset = 1'b1;
        applyStimulus(8'd5, 8'd6, 16'h001E, 11, "after_reset_5_6");

        // go held high: back-to-back -1 x -1 with a single idle edge between.
        startOp(8'hFF, 8'hFF, 16'h0001, 11, "b2b_first");
        pushExpected(16'h0001, 11, "b2b_second");
        @(posedge reloj);
        waitDone("b2b_first");
        @(posedge reloj);
        checkOutput("b2b_no_dead_cycle", int'(bus.done), 0);
        bus.go = 1'b0;
        waitDone("b2b_second");

        repeat (3) @(posedge reloj);
        checkOutput("scoreboard_empty", sbQueue.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
